// File: rtl/bi_mem_wm_arb_pkg.sv
// rtl/bi_mem_wm_arb_pkg.sv - shared types and helpers for the masked-memory write arbiter
package bi_mem_wm_arb_pkg;

  // Sweep phase versus normal arbitration phase
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } arb_state_e;

  // Word address width; at least one bit even for tiny memories
  function automatic int calc_aw(input int height);
    return (height > 2) ? $clog2(height) : 1;
  endfunction

endpackage

// File: rtl/bi_rr_arb.sv
// rtl/bi_rr_arb.sv - N-way round-robin arbiter with internal priority pointer
module bi_rr_arb #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  valid_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] winner_o
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_next_ptr;
  logic          w_found;
  logic [IW-1:0] w_idx;
  int            w_sum;

  // Search from the pointer upward, wrapping, and pick the first valid requester
  always_comb begin
    grant_o  = '0;
    winner_o = r_ptr;
    w_found  = 1'b0;
    w_idx    = '0;
    w_sum    = 0;
    for (int k = 0; k < N; k++) begin
      w_sum = int'(r_ptr) + k;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = IW'(w_sum);
      if (!w_found && valid_i[w_idx]) begin
        w_found        = 1'b1;
        grant_o[w_idx] = 1'b1;
        winner_o       = w_idx;
      end
    end
  end

  // Pointer moves just past the winner so it loses priority next time
  always_comb begin
    w_next_ptr = (int'(winner_o) == N - 1) ? '0 : winner_o + 1'b1;
  end

  // Pointer only moves when the caller reports a completed handshake
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr <= '0;
    end else if (advance_i) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/bi_mem_tp_wm_wr_arb.sv
// rtl/bi_mem_tp_wm_wr_arb.sv - shared masked write port with clear sweep and round-robin grant
module bi_mem_tp_wm_wr_arb
  import bi_mem_wm_arb_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int HEIGHT = 16,
  parameter int MASK   = 4,
  parameter int REQ    = 2,
  parameter int AW     = calc_aw(HEIGHT)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  output logic               busy_o,
  input  logic [REQ-1:0]     req_valid_i,
  output logic [REQ-1:0]     req_ready_o,
  input  logic [REQ*AW-1:0]  req_addr_i,
  input  logic [REQ*MASK-1:0] req_mask_i,
  input  logic [REQ*WIDTH-1:0] req_data_i,
  output logic               mem_we_o,
  output logic [MASK-1:0]    mem_mask_o,
  output logic [AW-1:0]      mem_addr_o,
  output logic [WIDTH-1:0]   mem_data_o
);

  localparam int IW = (REQ > 1) ? $clog2(REQ) : 1;

  arb_state_e       r_state;
  arb_state_e       w_state_nxt;
  logic [AW-1:0]    r_cnt;
  logic             w_last;
  logic             w_grant_en;
  logic             w_hs;
  logic [REQ-1:0]   w_grant;
  logic [IW-1:0]    w_winner;
  logic [AW-1:0]    w_addr;
  logic [MASK-1:0]  w_mask;
  logic [WIDTH-1:0] w_data;

  assign w_last = (r_cnt == AW'(HEIGHT - 1));

  bi_rr_arb #(
    .N  (REQ),
    .IW (IW)
  ) u_rr_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (req_valid_i),
    .advance_i (w_hs),
    .grant_o   (w_grant),
    .winner_o  (w_winner)
  );

  // State register: every reset starts a fresh sweep
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Sweep ends after the last word; a clear pulse only matters while running
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (w_last)  w_state_nxt = ST_RUN;
      ST_RUN:   if (clear_i) w_state_nxt = ST_CLEAR;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // Grants are suppressed during the sweep and in the cycle a clear is requested
  always_comb begin
    busy_o      = (r_state == ST_CLEAR);
    w_grant_en  = (r_state == ST_RUN) && !clear_i;
    req_ready_o = w_grant & {REQ{w_grant_en}};
    w_hs        = |req_ready_o;
  end

  // Sweep address counter, rewound whenever a new sweep is armed
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (r_state == ST_CLEAR) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
    end else if (clear_i) begin
      r_cnt <= '0;
    end
  end

  // Select the winning requester's payload
  always_comb begin
    w_addr = '0;
    w_mask = '0;
    w_data = '0;
    for (int i = 0; i < REQ; i++) begin
      if (w_grant[i]) begin
        w_addr = req_addr_i[i*AW +: AW];
        w_mask = req_mask_i[i*MASK +: MASK];
        w_data = req_data_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // Registered write port: sweep writes take precedence, idle cycles drop the enable
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_we_o   <= 1'b0;
      mem_mask_o <= '0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else if (r_state == ST_CLEAR) begin
      mem_we_o   <= 1'b1;
      mem_mask_o <= '1;
      mem_addr_o <= r_cnt;
      mem_data_o <= '0;
    end else if (w_hs) begin
      mem_we_o   <= 1'b1;
      mem_mask_o <= w_mask;
      mem_addr_o <= w_addr;
      mem_data_o <= w_data;
    end else begin
      mem_we_o   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bi_mem_tp_wm_wr_arb.sv
// tb/tb_bi_mem_tp_wm_wr_arb.sv - randomized self-checking bench for the masked write arbiter
module tb_bi_mem_tp_wm_wr_arb;

  localparam int W  = 16;
  localparam int H  = 16;
  localparam int M  = 4;
  localparam int R  = 2;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, clr, busy, we;
  logic [R-1:0]   v, rdy;
  logic [R*AW-1:0] a;
  logic [R*M-1:0] mk;
  logic [R*W-1:0] d;
  logic [M-1:0]   mmask;
  logic [AW-1:0]  maddr;
  logic [W-1:0]   mdata;

  logic           rst2, busy2, we2;
  logic [R-1:0]   rdy2;
  logic [M-1:0]   mask2;
  logic [AW-1:0]  addr2;
  logic [W-1:0]   data2;

  bi_mem_tp_wm_wr_arb #(.WIDTH(W), .HEIGHT(H), .MASK(M), .REQ(R)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clear_i(clr), .busy_o(busy),
    .req_valid_i(v), .req_ready_o(rdy), .req_addr_i(a), .req_mask_i(mk), .req_data_i(d),
    .mem_we_o(we), .mem_mask_o(mmask), .mem_addr_o(maddr), .mem_data_o(mdata)
  );

  bi_mem_tp_wm_wr_arb #(.WIDTH(W), .HEIGHT(10), .MASK(M), .REQ(R)) dut10 (
    .clk_i(clk), .rst_ni(rst2), .clear_i(1'b0), .busy_o(busy2),
    .req_valid_i({R{1'b0}}), .req_ready_o(rdy2), .req_addr_i({(R*AW){1'b0}}),
    .req_mask_i({(R*M){1'b0}}), .req_data_i({(R*W){1'b0}}),
    .mem_we_o(we2), .mem_mask_o(mask2), .mem_addr_o(addr2), .mem_data_o(data2)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  bit             m_busy;
  int             m_cnt, m_ptr;
  bit             e_we;
  logic [AW-1:0]  e_addr;
  logic [M-1:0]   e_mask;
  logic [W-1:0]   e_data;
  logic [W-1:0]   mem_m [H];
  int             p [R];
  bit             rnd_clr;
  logic [R-1:0]   hs;
  int             n_busy_cyc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle();
    logic [R-1:0]  x_rdy;
    int            win;
    bit            n_we;
    logic [AW-1:0] n_addr;
    logic [M-1:0]  n_mask;
    logic [W-1:0]  n_data;
    @(negedge clk);
    x_rdy = '0; win = -1; n_we = 0; n_addr = '0; n_mask = '0; n_data = '0;
    if (m_busy) begin
      n_we = 1; n_addr = AW'(m_cnt); n_mask = '1; n_data = '0;
    end else if (!clr) begin
      for (int k = 0; k < R; k++) begin
        int i;
        i = (m_ptr + k) % R;
        if (win < 0 && v[i]) win = i;
      end
      if (win >= 0) begin
        x_rdy[win] = 1'b1; n_we = 1;
        n_addr = a[win*AW +: AW]; n_mask = mk[win*M +: M]; n_data = d[win*W +: W];
      end
    end
    chk("ready", rdy, x_rdy);
    chk("busy", busy, m_busy);
    chk("mem_we", we, e_we);
    if (e_we) begin
      chk("mem_addr", maddr, e_addr);
      chk("mem_mask", mmask, e_mask);
      chk("mem_data", mdata, e_data);
    end
    if (we) begin
      for (int b = 0; b < M; b++)
        if (mmask[b]) mem_m[maddr][b*4 +: 4] = mdata[b*4 +: 4];
    end
    if (busy) n_busy_cyc++;
    hs = v & rdy;
    e_we = n_we; e_addr = n_addr; e_mask = n_mask; e_data = n_data;
    if (m_busy) begin
      m_cnt++;
      if (m_cnt == H) m_busy = 0;
    end else if (clr) begin
      m_busy = 1; m_cnt = 0;
    end else if (win >= 0) begin
      m_ptr = (win + 1) % R;
    end
    @(posedge clk);
    #1;
    clr = rnd_clr && ($urandom_range(59) == 0);
    for (int i = 0; i < R; i++) begin
      if (!v[i] || hs[i]) begin
        v[i] = ($urandom_range(99) < p[i]);
        a[i*AW +: AW] = AW'($urandom);
        mk[i*M +: M]  = M'($urandom);
        d[i*W +: W]   = W'($urandom);
      end
    end
  endtask

  task automatic write_one(input int i, input logic [AW-1:0] ad, input logic [M-1:0] ms,
                           input logic [W-1:0] dt);
    int n;
    v[i] = 1'b1; a[i*AW +: AW] = ad; mk[i*M +: M] = ms; d[i*W +: W] = dt;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!hs[i] && n < 20);
    chk("write_one_granted", hs[i], 1);
  endtask

  initial begin
    bit found;
    int k, b, n;
    rst_n = 0; rst2 = 0; clr = 0; v = '0; a = '0; mk = '0; d = '0;
    rnd_clr = 0; p[0] = 0; p[1] = 0;
    for (int i = 0; i < H; i++) mem_m[i] = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", we, 0);
    chk("rst_mask", mmask, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_data", mdata, 0);
    chk("rst_busy", busy, 1);
    chk("rst_ready", rdy, 0);

    // non-power-of-two sweep interrupted by reset at address 7
    rst2 = 1;
    found = 0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (we2 && addr2 == 7) found = 1;
    end
    chk("h10_reach7", found, 1);
    #2 rst2 = 0;
    #1;
    chk("h10_rst_we", we2, 0);
    chk("h10_rst_addr", addr2, 0);
    chk("h10_rst_mask", mask2, 0);
    chk("h10_rst_busy", busy2, 1);
    @(posedge clk);
    #1 rst2 = 1;
    k = 0; b = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (busy2) b++;
      if (we2) begin
        chk("h10_addr", addr2, k);
        chk("h10_mask", mask2, 4'hF);
        chk("h10_data", data2, 0);
        k++;
      end
    end
    chk("h10_words", k, 10);
    chk("h10_busy_len", b, 10);

    // main instance: sweep after reset release
    @(posedge clk);
    #1 rst_n = 1;
    m_busy = 1; m_cnt = 0; m_ptr = 0; e_we = 0; n_busy_cyc = 0;
    repeat (20) cycle();
    chk("busy_len", n_busy_cyc, 16);
    for (int i = 0; i < H; i++) chk("clear_mem", mem_m[i], 0);

    // both requesters saturating
    p[0] = 100; p[1] = 100;
    repeat (10) cycle();
    p[0] = 0; p[1] = 0;
    repeat (3) cycle();

    // only requester 1, then both
    p[1] = 100;
    repeat (5) cycle();
    p[0] = 100;
    repeat (4) cycle();
    p[0] = 0; p[1] = 0;
    repeat (3) cycle();

    // partial-mask merge over an existing word
    write_one(0, 4'd3, 4'hF, 16'h1234);
    write_one(0, 4'd3, 4'b0101, 16'hABCD);
    repeat (2) cycle();
    chk("mask_merge", mem_m[3], 16'h1B3D);

    // zero mask still issues a write
    write_one(1, 4'd5, 4'h0, 16'hFFFF);
    repeat (2) cycle();

    // clear pulse coinciding with a request
    clr = 1; v[0] = 1'b1; a[0 +: AW] = 4'd9; mk[0 +: M] = 4'hF; d[0 +: W] = 16'h5A5A;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!hs[0] && n < 40);
    chk("clr_grant_lat", n, 18);
    repeat (2) cycle();
    chk("clr_then_write", mem_m[9], 16'h5A5A);

    // random traffic with occasional clears
    p[0] = 50; p[1] = 50; rnd_clr = 1;
    repeat (300) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
